// File: rtl/sdram_mport_arbiter.sv
// N-port round-robin front-end for a single Avalon-MM SDRAM controller slave.
// A registered command slot feeds the controller; a tag FIFO steers read data back to its issuer.
module sdram_mport_arbiter #(
    parameter int  NUM_PORTS   = 4,
    parameter int  ADDR_W      = 22,
    parameter int  DATA_W      = 16,
    parameter int  MAX_PENDING = 8,
    localparam int BE_W        = DATA_W / 8,
    localparam int CNT_W       = $clog2(MAX_PENDING) + 1,
    localparam int IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int PTR_W       = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_address,
    input  logic [NUM_PORTS*DATA_W-1:0] p_writedata,
    input  logic [NUM_PORTS*BE_W-1:0]   p_byteenable,
    input  logic [NUM_PORTS-1:0]        p_read,
    input  logic [NUM_PORTS-1:0]        p_write,
    output logic [NUM_PORTS-1:0]        p_waitrequest,
    output logic [DATA_W-1:0]           p_readdata,
    output logic [NUM_PORTS-1:0]        p_readdatavalid,
    output logic [ADDR_W-1:0]           m_address,
    output logic [BE_W-1:0]             m_byteenable_n,
    output logic                        m_chipselect,
    output logic [DATA_W-1:0]           m_writedata,
    output logic                        m_read_n,
    output logic                        m_write_n,
    input  logic [DATA_W-1:0]           m_readdata,
    input  logic                        m_readdatavalid,
    input  logic                        m_waitrequest,
    output logic [CNT_W-1:0]            pending_reads,
    output logic                        err_orphan_rdv
);

    logic                 slot_full_q, slot_full_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [BE_W-1:0]      ben_q, ben_d;
    logic                 read_n_q, read_n_d;
    logic                 write_n_q, write_n_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     wptr_q, rptr_q;
    logic [IDX_W-1:0]     tag_mem_q [MAX_PENDING];
    logic [DATA_W-1:0]    rdata_q;
    logic [NUM_PORTS-1:0] rdv_q, rdv_d;
    logic                 err_q, err_d;

    logic                 slot_free_s, pop_s, push_s, fifo_full_s;
    logic                 found_s, grant_vld_s, grant_wr_s;
    logic [IDX_W-1:0]     grant_s;
    logic [IDX_W:0]       idx_s;
    logic [NUM_PORTS-1:0] eligible_s;

    assign slot_free_s = !slot_full_q || !m_waitrequest;
    assign pop_s       = m_readdatavalid && (cnt_q != {CNT_W{1'b0}});
    // A pop in the same cycle frees an entry, so a full FIFO may still accept a read.
    assign fifo_full_s = (cnt_q == CNT_W'(MAX_PENDING)) && !pop_s;
    assign eligible_s  = p_write | (p_read & {NUM_PORTS{!fifo_full_s}});

    // Round-robin search starting just after the last granted port.
    always_comb begin
        grant_s = {IDX_W{1'b0}};
        found_s = 1'b0;
        idx_s   = {(IDX_W+1){1'b0}};
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx_s = {1'b0, last_q} + (IDX_W+1)'(k);
            if (idx_s >= (IDX_W+1)'(NUM_PORTS)) begin
                idx_s = idx_s - (IDX_W+1)'(NUM_PORTS);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && eligible_s[idx_s[IDX_W-1:0]]) begin
                found_s = 1'b1;
                grant_s = idx_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant_vld_s   = found_s && slot_free_s && reset_n;
    assign grant_wr_s    = p_write[grant_s];
    assign push_s        = grant_vld_s && !grant_wr_s;
    assign p_waitrequest = grant_vld_s ? ~(NUM_PORTS'(1) << grant_s) : {NUM_PORTS{1'b1}};

    // Next-state for the command slot, tag count, return path and error flag.
    always_comb begin
        slot_full_d = slot_full_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ben_d       = ben_q;
        read_n_d    = read_n_q;
        write_n_d   = write_n_q;
        last_d      = last_q;
        if (slot_free_s) begin
            if (grant_vld_s) begin
                slot_full_d = 1'b1;
                addr_d      = p_address[grant_s*ADDR_W +: ADDR_W];
                wdata_d     = p_writedata[grant_s*DATA_W +: DATA_W];
                ben_d       = ~p_byteenable[grant_s*BE_W +: BE_W];
                read_n_d    = grant_wr_s;
                write_n_d   = !grant_wr_s;
                last_d      = grant_s;
            end else begin
                slot_full_d = 1'b0;
                read_n_d    = 1'b1;
                write_n_d   = 1'b1;
            end
        end else begin
            slot_full_d = slot_full_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (pop_s) begin
            rdv_d = NUM_PORTS'(1) << tag_mem_q[rptr_q];
        end else begin
            rdv_d = {NUM_PORTS{1'b0}};
        end
        err_d = err_q | (m_readdatavalid && (cnt_q == {CNT_W{1'b0}}));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_full_q <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            ben_q       <= {BE_W{1'b1}};
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            last_q      <= IDX_W'(NUM_PORTS - 1);
            cnt_q       <= {CNT_W{1'b0}};
            wptr_q      <= {PTR_W{1'b0}};
            rptr_q      <= {PTR_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            rdv_q       <= {NUM_PORTS{1'b0}};
            err_q       <= 1'b0;
        end else begin
            slot_full_q <= slot_full_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ben_q       <= ben_d;
            read_n_q    <= read_n_d;
            write_n_q   <= write_n_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            wptr_q      <= push_s ? wptr_q + PTR_W'(1) : wptr_q;
            rptr_q      <= pop_s ? rptr_q + PTR_W'(1) : rptr_q;
            rdata_q     <= m_readdata;
            rdv_q       <= rdv_d;
            err_q       <= err_d;
        end
    end

    // Tag storage; writes only happen on an accepted read, which reset suppresses.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_q[wptr_q] <= grant_s;
        end else begin
            tag_mem_q[wptr_q] <= tag_mem_q[wptr_q];
        end
    end

    assign m_chipselect    = slot_full_q;
    assign m_address       = addr_q;
    assign m_writedata     = wdata_q;
    assign m_byteenable_n  = ben_q;
    assign m_read_n        = read_n_q;
    assign m_write_n       = write_n_q;
    assign p_readdata      = rdata_q;
    assign p_readdatavalid = rdv_q;
    assign pending_reads   = cnt_q;
    assign err_orphan_rdv  = err_q;

endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// Randomised bench for sdram_mport_arbiter: a spec-level model predicts grants, controller
// commands and routed read data; monitors compare them as the DUT presents outputs.
module tb_sdram_mport_arbiter;
    localparam int NP = 4;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int MP = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP*AW-1:0]  p_address;
    logic [NP*DW-1:0]  p_writedata;
    logic [NP*BW-1:0]  p_byteenable;
    logic [NP-1:0]     p_read, p_write, p_waitrequest, p_readdatavalid;
    logic [DW-1:0]     p_readdata, m_writedata, m_readdata;
    logic [AW-1:0]     m_address;
    logic [BW-1:0]     m_byteenable_n;
    logic              m_chipselect, m_read_n, m_write_n, m_readdatavalid, m_waitrequest;
    logic [CW-1:0]     pending_reads;
    logic              err_orphan_rdv;

    sdram_mport_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) u_dut (
        .clk(clk), .reset_n(reset_n), .p_address(p_address), .p_writedata(p_writedata),
        .p_byteenable(p_byteenable), .p_read(p_read), .p_write(p_write),
        .p_waitrequest(p_waitrequest), .p_readdata(p_readdata), .p_readdatavalid(p_readdatavalid),
        .m_address(m_address), .m_byteenable_n(m_byteenable_n), .m_chipselect(m_chipselect),
        .m_writedata(m_writedata), .m_read_n(m_read_n), .m_write_n(m_write_n),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
        .pending_reads(pending_reads), .err_orphan_rdv(err_orphan_rdv));

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be; bit wr; } cmd_t;
    typedef struct { int port; logic [DW-1:0] d; int due; } ret_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit run_chk  = 1'b0;

    // Per-port master state (request held until accepted).
    bit            act_r [NP];
    bit            rd_r  [NP];
    bit            wr_r  [NP];
    logic [AW-1:0] ad_r  [NP];
    logic [DW-1:0] wd_r  [NP];
    logic [BW-1:0] be_r  [NP];

    cmd_t cmdq [$];
    int   tagq [$];
    ret_t retq [$];
    int   ctrl_rd = 0;
    int   last_m  = NP - 1;
    int   wait_pct, rdv_pct, req_pct;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic drive_ports();
        for (int i = 0; i < NP; i++) begin
            p_read[i]                = act_r[i] & rd_r[i];
            p_write[i]               = act_r[i] & wr_r[i];
            p_address[i*AW +: AW]    = ad_r[i];
            p_writedata[i*DW +: DW]  = wd_r[i];
            p_byteenable[i*BW +: BW] = be_r[i];
        end
    endtask

    task automatic new_reqs();
        int k;
        for (int i = 0; i < NP; i++) begin
            if (!act_r[i] && $urandom_range(99) < req_pct) begin
                k        = $urandom_range(9);
                act_r[i] = 1'b1;
                wr_r[i]  = (k >= 5);
                rd_r[i]  = (k < 5) || (k == 9);
                ad_r[i]  = ($urandom_range(3) == 0) ? {AW{1'b1}} : AW'($urandom);
                wd_r[i]  = DW'($urandom);
                be_r[i]  = BW'($urandom);
            end
        end
    endtask

    // One bus cycle: check occupancy, drive controller and masters, predict the grant.
    task automatic step();
        int   g, p;
        bit   full_m;
        ret_t r;
        cmd_t c;
        logic [NP-1:0] ew;
        @(posedge clk); #1;
        chk(pending_reads == CW'(tagq.size()), "pending_reads", pending_reads, tagq.size());
        m_waitrequest = ($urandom_range(99) < wait_pct);
        if (ctrl_rd > 0 && $urandom_range(99) < rdv_pct) begin
            ctrl_rd--;
            r.port = tagq.pop_front();
            r.d    = DW'($urandom);
            r.due  = cyc + 1;
            retq.push_back(r);
            m_readdatavalid = 1'b1;
            m_readdata      = r.d;
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata      = DW'($urandom);
        end
        new_reqs();
        drive_ports();
        @(negedge clk); #1;
        full_m = (tagq.size() >= MP);
        g = -1;
        if (cmdq.size() == 0) begin
            for (int k = 1; k <= NP; k++) begin
                p = (last_m + k) % NP;
                if (g < 0 && act_r[p] && (wr_r[p] || (rd_r[p] && !full_m))) g = p;
            end
        end
        ew = '1;
        if (g >= 0) ew[g] = 1'b0;
        chk(p_waitrequest == ew, "p_waitrequest", p_waitrequest, ew);
        if (g >= 0) begin
            c.a = ad_r[g]; c.d = wd_r[g]; c.be = be_r[g]; c.wr = wr_r[g];
            cmdq.push_back(c);
            if (!wr_r[g]) tagq.push_back(g);
            last_m   = g;
            act_r[g] = 1'b0;
        end
    endtask

    // Monitor: compare the controller-side slot and the routed read return.
    initial forever begin
        cmd_t c;
        ret_t r;
        @(negedge clk);
        if (run_chk) begin
            if (m_chipselect) begin
                if (cmdq.size() == 0) chk(1'b0, "unexpected_cmd", 1, 0);
                else begin
                    c = cmdq[0];
                    chk(m_address == c.a, "m_address", m_address, c.a);
                    chk(m_write_n == !c.wr, "m_write_n", m_write_n, !c.wr);
                    chk(m_read_n == c.wr, "m_read_n", m_read_n, c.wr);
                    chk(m_byteenable_n == ~c.be, "m_byteenable_n", m_byteenable_n, ~c.be);
                    if (c.wr) chk(m_writedata == c.d, "m_writedata", m_writedata, c.d);
                    if (!m_waitrequest) begin
                        void'(cmdq.pop_front());
                        if (!c.wr) ctrl_rd++;
                    end
                end
            end else if (cmdq.size() != 0) begin
                chk(1'b0, "missing_cmd", 0, 1);
                cmdq.delete();
            end
            if (p_readdatavalid != '0) begin
                if (retq.size() == 0) chk(1'b0, "unexpected_rdv", p_readdatavalid, 0);
                else begin
                    r = retq.pop_front();
                    chk(p_readdatavalid == (NP'(1) << r.port), "rdv_port", p_readdatavalid, NP'(1) << r.port);
                    chk(p_readdata == r.d, "p_readdata", p_readdata, r.d);
                    chk(cyc == r.due, "rdv_latency", cyc, r.due);
                end
            end else if (retq.size() != 0 && retq[0].due <= cyc) begin
                chk(1'b0, "missing_rdv", cyc, retq[0].due);
                void'(retq.pop_front());
            end
        end
    end

    task automatic phase(input int n, input int wp, input int rp, input int qp);
        wait_pct = wp; rdv_pct = rp; req_pct = qp;
        repeat (n) step();
    endtask

    initial begin
        bit drained;
        for (int i = 0; i < NP; i++) begin
            act_r[i] = 1'b0; rd_r[i] = 1'b0; wr_r[i] = 1'b0;
            ad_r[i] = '0; wd_r[i] = '0; be_r[i] = '0;
        end
        reset_n = 1'b0; drive_ports();
        p_read = 4'b1111;
        m_readdata = '0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk(p_waitrequest == 4'b1111, "rst_waitrequest", p_waitrequest, 4'b1111);
            chk(m_chipselect == 1'b0, "rst_chipselect", m_chipselect, 0);
            chk(m_read_n == 1'b1 && m_write_n == 1'b1, "rst_rw_n", {m_read_n, m_write_n}, 3);
            chk(pending_reads == '0, "rst_pending", pending_reads, 0);
            chk(err_orphan_rdv == 1'b0, "rst_err", err_orphan_rdv, 0);
        end
        reset_n = 1'b1;
        p_read  = '0;
        run_chk = 1'b1;

        phase(300, 20, 40, 60);   // mixed traffic
        phase(120, 10, 0, 80);    // no returns: FIFO fills, writes keep flowing
        phase(300, 30, 60, 70);   // drain and refill with heavy backpressure
        phase(100, 0, 30, 100);   // continuous requests, no backpressure

        drained = 1'b0;
        for (int n = 0; n < 200 && !drained; n++) begin
            phase(1, 0, 100, 0);
            drained = (cmdq.size() == 0) && (tagq.size() == 0) && (retq.size() == 0);
            for (int i = 0; i < NP; i++) if (act_r[i]) drained = 1'b0;
        end
        chk(drained, "drain_timeout", drained, 1);
        chk(err_orphan_rdv == 1'b0, "err_before_orphan", err_orphan_rdv, 0);

        @(posedge clk); #1;
        m_readdatavalid = 1'b1; m_readdata = 16'hDEAD;
        @(posedge clk); #1;
        m_readdatavalid = 1'b0;
        chk(err_orphan_rdv == 1'b1, "err_orphan_set", err_orphan_rdv, 1);
        repeat (5) @(posedge clk);
        #1;
        chk(err_orphan_rdv == 1'b1, "err_orphan_sticky", err_orphan_rdv, 1);
        chk(pending_reads == '0, "orphan_pending", pending_reads, 0);

        run_chk = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(err_orphan_rdv == 1'b0, "err_cleared", err_orphan_rdv, 0);
        chk(m_chipselect == 1'b0, "rst2_chipselect", m_chipselect, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
